// File: rtl/cursor_overlay_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : cursor_overlay_ctrl
//  Brief    : Debounces cursor/intensity push-buttons, keeps a clamped pending
//             cursor centre and intensity level, and commits them to the
//             outputs only at frame end so the pixel stage never sees a
//             mid-frame change.
//  Options  : CURSOR_AUTOREPEAT_EN - hold-to-repeat on the direction keys.
//  Revision : 1.0 - initial release
// ============================================================================
module cursor_overlay_ctrl #(
    parameter int H_ACTIVE        = 640,
    parameter int V_ACTIVE        = 480,
    parameter int SQUARE          = 8,
    parameter int STEP            = 4,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic        iCLK,
    input  logic        iRST_N,
    input  logic        iKEY_UP,
    input  logic        iKEY_DOWN,
    input  logic        iKEY_LEFT,
    input  logic        iKEY_RIGHT,
    input  logic        iMODE_STEP,
    input  logic        iFRAME_END,
    output logic [12:0] oCENTER_ROW,
    output logic [12:0] oCENTER_COL,
    output logic [1:0]  oICONTROL,
    output logic        oUPDATED
);

    // Key slot indices into the per-key vectors
    localparam int c_K_UP    = 0;
    localparam int c_K_DOWN  = 1;
    localparam int c_K_LEFT  = 2;
    localparam int c_K_RIGHT = 3;
    localparam int c_K_MODE  = 4;
    localparam int c_NKEYS   = 5;

    localparam int                c_DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [c_DB_W-1:0] c_DB_LAST = c_DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_DB_W-1:0] c_DB_ONE  = c_DB_W'(1);

`ifdef CURSOR_AUTOREPEAT_EN
    localparam int                c_RP_MAX     = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int                c_RP_W       = $clog2(c_RP_MAX + 1);
    localparam logic [c_RP_W-1:0] c_DELAY_LAST = c_RP_W'(REPEAT_DELAY - 1);
    localparam logic [c_RP_W-1:0] c_PER_LAST   = c_RP_W'(REPEAT_PERIOD - 1);
    localparam logic [c_RP_W-1:0] c_RP_ONE     = c_RP_W'(1);
`endif

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_HOLD   = 2'd1;
    localparam logic [1:0] c_ST_REPEAT = 2'd2;

    // Signed 14-bit clamp bounds so an underflow clamps instead of wrapping
    localparam logic signed [13:0] c_STEP_S  = 14'(STEP);
    localparam logic signed [13:0] c_COL_MIN = 14'(SQUARE / 2);
    localparam logic signed [13:0] c_COL_MAX = 14'(H_ACTIVE - 1 - SQUARE / 2);
    localparam logic signed [13:0] c_ROW_MIN = 14'(SQUARE / 2);
    localparam logic signed [13:0] c_ROW_MAX = 14'(V_ACTIVE - 1 - SQUARE / 2);
    localparam logic [12:0]        c_COL_RST = 13'(H_ACTIVE / 2);
    localparam logic [12:0]        c_ROW_RST = 13'(V_ACTIVE / 2);

    logic [c_NKEYS-1:0] w_raw;
    logic [c_NKEYS-1:0] w_evt;

    assign w_raw = {iMODE_STEP, iKEY_RIGHT, iKEY_LEFT, iKEY_DOWN, iKEY_UP};

    genvar gi;
    generate
        for (gi = 0; gi < c_NKEYS; gi++) begin : g_key
`ifdef CURSOR_AUTOREPEAT_EN
            localparam logic c_CAN_REPEAT = (gi != c_K_MODE);
            logic [c_RP_W-1:0] r_rcnt;
`endif
            logic [1:0]        r_sync;
            logic [c_DB_W-1:0] r_dbcnt;
            logic              r_db;
            logic [1:0]        r_state;
            logic              r_evt;

            // Two-flop synchronizer for the asynchronous button
            always_ff @(posedge iCLK or negedge iRST_N) begin
                if (!iRST_N) r_sync <= 2'b00;
                else         r_sync <= {r_sync[0], w_raw[gi]};
            end

            // Debounced level follows the synchronized level after a full stable run
            always_ff @(posedge iCLK or negedge iRST_N) begin
                if (!iRST_N) begin
                    r_dbcnt <= '0;
                    r_db    <= 1'b0;
                end else if (r_sync[1] != r_db) begin
                    if (r_dbcnt == c_DB_LAST) begin
                        r_db    <= r_sync[1];
                        r_dbcnt <= '0;
                    end else begin
                        r_dbcnt <= r_dbcnt + c_DB_ONE;
                    end
                end else begin
                    r_dbcnt <= '0;
                end
            end

            // Press/hold FSM: one event on the debounced rise, optional repeats while held
            always_ff @(posedge iCLK or negedge iRST_N) begin
                if (!iRST_N) begin
                    r_state <= c_ST_IDLE;
                    r_evt   <= 1'b0;
`ifdef CURSOR_AUTOREPEAT_EN
                    r_rcnt  <= '0;
`endif
                end else begin
                    r_evt <= 1'b0;
                    case (r_state)
                        c_ST_IDLE: begin
                            if (r_db) begin
                                r_state <= c_ST_HOLD;
                                r_evt   <= 1'b1;
`ifdef CURSOR_AUTOREPEAT_EN
                                r_rcnt  <= '0;
`endif
                            end
                        end
                        c_ST_HOLD: begin
                            if (!r_db) begin
                                r_state <= c_ST_IDLE;
                            end
`ifdef CURSOR_AUTOREPEAT_EN
                            else if (c_CAN_REPEAT) begin
                                if (r_rcnt == c_DELAY_LAST) begin
                                    r_state <= c_ST_REPEAT;
                                    r_evt   <= 1'b1;
                                    r_rcnt  <= '0;
                                end else begin
                                    r_rcnt <= r_rcnt + c_RP_ONE;
                                end
                            end
`endif
                        end
                        c_ST_REPEAT: begin
                            if (!r_db) begin
                                r_state <= c_ST_IDLE;
                            end
`ifdef CURSOR_AUTOREPEAT_EN
                            else if (r_rcnt == c_PER_LAST) begin
                                r_evt  <= 1'b1;
                                r_rcnt <= '0;
                            end else begin
                                r_rcnt <= r_rcnt + c_RP_ONE;
                            end
`endif
                        end
                        default: r_state <= c_ST_IDLE;
                    endcase
                end
            end

            assign w_evt[gi] = r_evt;
        end
    endgenerate

    logic [12:0]        r_pend_row;
    logic [12:0]        r_pend_col;
    logic [1:0]         r_pend_lvl;
    logic signed [13:0] w_col_sum;
    logic signed [13:0] w_row_sum;
    logic [12:0]        w_col_next;
    logic [12:0]        w_row_next;

    // Next pending position: opposing events cancel, result clamped to the visible area
    always_comb begin
        w_col_sum = $signed({1'b0, r_pend_col});
        w_row_sum = $signed({1'b0, r_pend_row});
        if (w_evt[c_K_RIGHT] && !w_evt[c_K_LEFT])      w_col_sum = w_col_sum + c_STEP_S;
        else if (w_evt[c_K_LEFT] && !w_evt[c_K_RIGHT]) w_col_sum = w_col_sum - c_STEP_S;
        if (w_evt[c_K_DOWN] && !w_evt[c_K_UP])         w_row_sum = w_row_sum + c_STEP_S;
        else if (w_evt[c_K_UP] && !w_evt[c_K_DOWN])    w_row_sum = w_row_sum - c_STEP_S;

        if (w_col_sum < c_COL_MIN)      w_col_next = c_COL_MIN[12:0];
        else if (w_col_sum > c_COL_MAX) w_col_next = c_COL_MAX[12:0];
        else                            w_col_next = w_col_sum[12:0];

        if (w_row_sum < c_ROW_MIN)      w_row_next = c_ROW_MIN[12:0];
        else if (w_row_sum > c_ROW_MAX) w_row_next = c_ROW_MAX[12:0];
        else                            w_row_next = w_row_sum[12:0];
    end

    // Pending registers absorb step events every cycle
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            r_pend_row <= c_ROW_RST;
            r_pend_col <= c_COL_RST;
            r_pend_lvl <= 2'd0;
        end else begin
            r_pend_row <= w_row_next;
            r_pend_col <= w_col_next;
            if (w_evt[c_K_MODE]) r_pend_lvl <= r_pend_lvl + 2'd1;
        end
    end

    // Frame-end commit copies the pre-event pending values and flags a change
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            oCENTER_ROW <= c_ROW_RST;
            oCENTER_COL <= c_COL_RST;
            oICONTROL   <= 2'd0;
            oUPDATED    <= 1'b0;
        end else if (iFRAME_END) begin
            oCENTER_ROW <= r_pend_row;
            oCENTER_COL <= r_pend_col;
            oICONTROL   <= r_pend_lvl;
            oUPDATED    <= (r_pend_row != oCENTER_ROW) || (r_pend_col != oCENTER_COL) ||
                           (r_pend_lvl != oICONTROL);
        end else begin
            oUPDATED <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cursor_overlay_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cursor_overlay_ctrl
//  Brief    : Table-driven, scoreboard-checked bench for cursor_overlay_ctrl.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cursor_overlay_ctrl;

    localparam logic [4:0] c_UP    = 5'b00001;
    localparam logic [4:0] c_DOWN  = 5'b00010;
    localparam logic [4:0] c_LEFT  = 5'b00100;
    localparam logic [4:0] c_RIGHT = 5'b01000;
    localparam logic [4:0] c_MODE  = 5'b10000;
`ifdef CURSOR_AUTOREPEAT_EN
    localparam int c_COL_HELD = 607;
`else
    localparam int c_COL_HELD = 631;
`endif

    typedef struct {
        logic [12:0] row;
        logic [12:0] col;
        logic [1:0]  lvl;
        logic        upd;
    } exp_t;

    typedef struct {
        logic [4:0] keys;
        int         presses;
        int         hold;
        exp_t       exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [4:0]  keys = 5'b0;
    logic        frame_end = 1'b0;
    logic [12:0] o_row;
    logic [12:0] o_col;
    logic [1:0]  o_lvl;
    logic        o_upd;

    int   n_checks = 0;
    int   n_pass   = 0;
    exp_t sb[$];
    exp_t e_mon;
    logic fe_seen = 1'b0;
    bit   fe_prev = 1'b0;
    vec_t vecs[14];

    cursor_overlay_ctrl #(
        .H_ACTIVE(640), .V_ACTIVE(480), .SQUARE(8), .STEP(4),
        .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(20), .REPEAT_PERIOD(5)
    ) dut (
        .iCLK(clk), .iRST_N(rst_n),
        .iKEY_UP(keys[0]), .iKEY_DOWN(keys[1]), .iKEY_LEFT(keys[2]),
        .iKEY_RIGHT(keys[3]), .iMODE_STEP(keys[4]),
        .iFRAME_END(frame_end),
        .oCENTER_ROW(o_row), .oCENTER_COL(o_col), .oICONTROL(o_lvl), .oUPDATED(o_upd)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, req);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [4:0] k, input int hold);
        keys = k;
        repeat (hold) tick();
        keys = 5'b0;
        repeat (12) tick();
    endtask

    task automatic frame(input exp_t e);
        sb.push_back(e);
        frame_end = 1'b1;
        tick();
        frame_end = 1'b0;
    endtask

    function automatic exp_t mk(input int row, input int col, input int lvl, input bit upd);
        exp_t e;
        e.row = 13'(row);
        e.col = 13'(col);
        e.lvl = 2'(lvl);
        e.upd = upd;
        return e;
    endfunction

    // Track which posedges sampled a frame-end pulse
    always @(posedge clk) fe_seen <= frame_end;

    // Compare committed outputs against the scoreboard one half-cycle after each commit
    always @(negedge clk) begin
        if (fe_seen) begin
            if (sb.size() == 0) begin
                check("scoreboard_underflow", 1, 0);
            end else begin
                e_mon = sb.pop_front();
                check("commit_row", int'(o_row), int'(e_mon.row));
                check("commit_col", int'(o_col), int'(e_mon.col));
                check("commit_lvl", int'(o_lvl), int'(e_mon.lvl));
                check("commit_upd", int'(o_upd), int'(e_mon.upd));
            end
        end else if (fe_prev) begin
            check("upd_one_cycle", int'(o_upd), 0);
        end
        fe_prev = fe_seen;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0]  = '{5'b0,           0,   8, mk(240, 320, 0, 0)};
        vecs[1]  = '{c_RIGHT,        1,   3, mk(240, 320, 0, 0)};
        vecs[2]  = '{c_RIGHT,        1,  10, mk(240, 324, 0, 1)};
        vecs[3]  = '{c_LEFT | c_RIGHT | c_UP, 1, 10, mk(236, 324, 0, 1)};
        vecs[4]  = '{c_MODE,         5,  10, mk(236, 324, 1, 1)};
        vecs[5]  = '{c_UP | c_DOWN,  1,  10, mk(236, 324, 1, 0)};
        vecs[6]  = '{c_DOWN | c_RIGHT, 2, 8, mk(244, 332, 1, 1)};
        vecs[7]  = '{c_LEFT,        85,   8, mk(244,   4, 1, 1)};
        vecs[8]  = '{c_LEFT,         2,   8, mk(244,   4, 1, 0)};
        vecs[9]  = '{c_DOWN,        60,   8, mk(475,   4, 1, 1)};
        vecs[10] = '{c_UP,         120,   8, mk(  4,   4, 1, 1)};
        vecs[11] = '{c_RIGHT,      200,   8, mk(  4, 635, 1, 1)};
        vecs[12] = '{c_MODE,         3,   8, mk(  4, 635, 0, 1)};
        vecs[13] = '{c_LEFT,         1,  48, mk(  4, c_COL_HELD, 0, 1)};

        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        check("reset_row", int'(o_row), 240);
        check("reset_col", int'(o_col), 320);
        check("reset_lvl", int'(o_lvl), 0);
        check("reset_upd", int'(o_upd), 0);

        foreach (vecs[i]) begin
            for (int p = 0; p < vecs[i].presses; p++) press(vecs[i].keys, vecs[i].hold);
            repeat (4) tick();
            frame(vecs[i].exp);
            repeat (4) tick();
        end

        // Event landing in the frame-end cycle commits one frame later
        keys = c_RIGHT;
        repeat (7) tick();
        frame(mk(4, c_COL_HELD, 0, 0));
        tick();
        frame(mk(4, c_COL_HELD + 4, 0, 1));
        keys = 5'b0;
        repeat (14) tick();

        // Asynchronous reset discards a pending change immediately
        press(c_DOWN, 10);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_rst_row", int'(o_row), 240);
        check("async_rst_col", int'(o_col), 320);
        check("async_rst_lvl", int'(o_lvl), 0);
        check("async_rst_upd", int'(o_upd), 0);
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        frame(mk(240, 320, 0, 0));
        repeat (4) tick();

        check("scoreboard_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
